// File: rtl/riscv_core_pkg.sv
// Shared core constants for the write-back path: widths, channel map and
// arbitration modes, plus a small wrap-around helper for channel pointers.
package riscv_core_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_WB_CH  = 3;

   // Write-back channel map (lower index = higher fixed priority)
   localparam int WB_CH_ALU  = 0;
   localparam int WB_CH_JB   = 1;
   localparam int WB_CH_DMEM = 2;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   // Channel index following idx, wrapping at n
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/wb_channel_fifo.sv
// Per-channel write-back FIFO holding {addr, data} entries.
// Head is visible combinationally so the arbiter can pop it on the grant edge.
// Macro WB_HAZARD_CHECK_EN: exposes a per-entry valid/addr view for the
// read-after-write hazard compare in the arbiter.
module wb_channel_fifo
   import riscv_core_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din_addr,
   input  logic [DATA_W-1:0] din_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data
`ifdef WB_HAZARD_CHECK_EN
   ,
   output logic [DEPTH-1:0]        entry_valid,
   output logic [DEPTH*ADDR_W-1:0] entry_addr
`endif
);

   localparam int WIDTH = ADDR_W + DATA_W;
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign head_addr = mem_q[rd_ptr_q][WIDTH-1 -: ADDR_W];
   assign head_data = mem_q[rd_ptr_q][DATA_W-1:0];

   // Pointer and occupancy next-state; push and pop together leave count unchanged
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
      else if (!do_push && do_pop) count_d = count_q - (PTR_W+1)'(1);
   end

   // Control state register; reset discards all pending entries
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset because count gates validity
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= {din_addr, din_data};
   end

`ifdef WB_HAZARD_CHECK_EN
   // Entry gi is live when its distance from the read pointer is below count
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
      assign entry_valid[gi] = ({1'b0, PTR_W'(gi) - rd_ptr_q}) < count_q;
      assign entry_addr[gi*ADDR_W +: ADDR_W] = mem_q[gi][WIDTH-1 -: ADDR_W];
   end
`endif

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-back arbiter: NUM_CH buffered producer channels share
// the single register_file write port, one registered write per cycle.
// Macro WB_HAZARD_CHECK_EN: adds chk_index1/2 -> chk_hazard1/2 compare ports.
module writeback_arbiter
   import riscv_core_pkg::*;
#(
   parameter int NUM_CH     = NUM_WB_CH,
   parameter int DATA_W     = XLEN,
   parameter int ADDR_W     = REG_ADDR_W,
   parameter int FIFO_DEPTH = 2,
   parameter int ARB_MODE   = int'(ARB_FIXED)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        req_valid,
   output logic [NUM_CH-1:0]        req_ready,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH*DATA_W-1:0] req_data,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_index,
   output logic [DATA_W-1:0]        wr_data,
   output logic                     pending
`ifdef WB_HAZARD_CHECK_EN
   ,
   input  logic [ADDR_W-1:0]        chk_index1,
   input  logic [ADDR_W-1:0]        chk_index2,
   output logic                     chk_hazard1,
   output logic                     chk_hazard2
`endif
);

   localparam int CH_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0] full, empty, push, pop;
   logic [ADDR_W-1:0] head_addr [NUM_CH];
   logic [DATA_W-1:0] head_data [NUM_CH];

   logic              grant_vld;
   logic [CH_W-1:0]   grant_idx;
   logic [CH_W-1:0]   rr_q, rr_d;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_index_q;
   logic [DATA_W-1:0] wr_data_q;

`ifdef WB_HAZARD_CHECK_EN
   localparam int NE = NUM_CH * FIFO_DEPTH;
   logic [NE-1:0]        ent_valid;
   logic [NE*ADDR_W-1:0] ent_addr;
`endif

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Ready is purely !full, so a full FIFO refuses even if it pops this edge
      assign push[gi] = req_valid[gi] && !full[gi];

      wb_channel_fifo #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
         .clk        (clk),
         .reset      (reset),
         .push       (push[gi]),
         .pop        (pop[gi]),
         .din_addr   (req_addr[gi*ADDR_W +: ADDR_W]),
         .din_data   (req_data[gi*DATA_W +: DATA_W]),
         .full       (full[gi]),
         .empty      (empty[gi]),
         .head_addr  (head_addr[gi]),
         .head_data  (head_data[gi])
`ifdef WB_HAZARD_CHECK_EN
         ,
         .entry_valid(ent_valid[gi*FIFO_DEPTH +: FIFO_DEPTH]),
         .entry_addr (ent_addr[gi*FIFO_DEPTH*ADDR_W +: FIFO_DEPTH*ADDR_W])
`endif
      );
   end

   assign req_ready = ~full;

   // Grant selection: scanning in reverse so the first channel in search order wins
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      if (ARB_MODE == int'(ARB_RR)) begin
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            int c;
            c = int'(rr_q) + k;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!empty[CH_W'(c)]) begin
               grant_vld = 1'b1;
               grant_idx = CH_W'(c);
            end
         end
      end else begin
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (!empty[CH_W'(k)]) begin
               grant_vld = 1'b1;
               grant_idx = CH_W'(k);
            end
         end
      end
   end

   // One-hot pop of the granted head and round-robin pointer advance
   always_comb begin
      pop  = '0;
      rr_d = rr_q;
      if (grant_vld) begin
         pop[grant_idx] = 1'b1;
         if (ARB_MODE == int'(ARB_RR)) rr_d = CH_W'(wrap_inc(int'(grant_idx), NUM_CH));
      end
   end

   // Registered write port; x0 entries are consumed without a write
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en_q    <= 1'b0;
         wr_index_q <= '0;
         wr_data_q  <= '0;
         rr_q       <= '0;
      end else begin
         wr_en_q <= grant_vld && (head_addr[grant_idx] != '0);
         rr_q    <= rr_d;
         if (grant_vld) begin
            wr_index_q <= head_addr[grant_idx];
            wr_data_q  <= head_data[grant_idx];
         end
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_index = wr_index_q;
   assign wr_data  = wr_data_q;
   assign pending  = (|(~empty)) | wr_en_q;

`ifdef WB_HAZARD_CHECK_EN
   // A nonzero index is hazardous while any live entry or the issuing write targets it
   function automatic logic hazard_hit(input logic [ADDR_W-1:0]    idx,
                                       input logic [NE-1:0]        v,
                                       input logic [NE*ADDR_W-1:0] a,
                                       input logic                 en,
                                       input logic [ADDR_W-1:0]    widx);
      logic hit;
      hit = en && (widx == idx);
      for (int e = 0; e < NE; e++) begin
         if (v[e] && (a[e*ADDR_W +: ADDR_W] == idx)) hit = 1'b1;
      end
      return hit && (idx != '0);
   endfunction

   assign chk_hazard1 = hazard_hit(chk_index1, ent_valid, ent_addr, wr_en_q, wr_index_q);
   assign chk_hazard2 = hazard_hit(chk_index2, ent_valid, ent_addr, wr_en_q, wr_index_q);
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: a fixed-priority instance and a
// round-robin instance, scoreboard queues checked on every issued write.
// Macro WB_HAZARD_CHECK_EN: also exercises the hazard compare ports.
module tb_writeback_arbiter;

   typedef logic [36:0] wb_t;   // {addr[4:0], data[31:0]}

   typedef struct {
      logic [2:0]  valid;
      logic [14:0] addr;
      logic [95:0] data;
      int          cycles;      // negedges after the push edge until pending drops
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req_valid, rr_valid;
   logic [2:0]  req_ready, rr_ready;
   logic [14:0] req_addr, rr_addr;
   logic [95:0] req_data, rr_data;
   logic        wr_en, rr_wr_en;
   logic [4:0]  wr_index, rr_wr_index;
   logic [31:0] wr_data, rr_wr_data;
   logic        pending, rr_pending;
`ifdef WB_HAZARD_CHECK_EN
   logic [4:0]  chk_index1, chk_index2;
   logic        chk_hazard1, chk_hazard2;
   logic [4:0]  rr_chk_index;
   logic        rr_chk_hazard1, rr_chk_hazard2;
`endif

   int  checks = 0;
   int  errors = 0;
   bit  mon_en = 1'b0;
   wb_t exp_q[$];
   wb_t rr_exp_q[$];

   always #5 clk = ~clk;

   writeback_arbiter #(.NUM_CH(3), .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2), .ARB_MODE(0)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
      .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data), .pending(pending)
`ifdef WB_HAZARD_CHECK_EN
      , .chk_index1(chk_index1), .chk_index2(chk_index2),
      .chk_hazard1(chk_hazard1), .chk_hazard2(chk_hazard2)
`endif
   );

   writeback_arbiter #(.NUM_CH(3), .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2), .ARB_MODE(1)) dut_rr (
      .clk(clk), .reset(reset),
      .req_valid(rr_valid), .req_ready(rr_ready), .req_addr(rr_addr), .req_data(rr_data),
      .wr_en(rr_wr_en), .wr_index(rr_wr_index), .wr_data(rr_wr_data), .pending(rr_pending)
`ifdef WB_HAZARD_CHECK_EN
      , .chk_index1(rr_chk_index), .chk_index2(rr_chk_index),
      .chk_hazard1(rr_chk_hazard1), .chk_hazard2(rr_chk_hazard2)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_ch(input int ch, input logic [4:0] a, input logic [31:0] d);
      req_valid[ch]        = 1'b1;
      req_addr[ch*5 +: 5]  = a;
      req_data[ch*32 +: 32] = d;
   endtask

   task automatic set_rr(input int ch, input logic [4:0] a, input logic [31:0] d);
      rr_valid[ch]         = 1'b1;
      rr_addr[ch*5 +: 5]   = a;
      rr_data[ch*32 +: 32] = d;
   endtask

   // Scoreboard for the fixed-priority instance: every write must match the queue head
   always @(negedge clk) begin
      if (!reset && mon_en && wr_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected got idx=%0d data=%0h required no write", wr_index, wr_data);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            if ({wr_index, wr_data} !== e) begin
               errors++;
               $display("FAIL wr_port got idx=%0d data=%0h required idx=%0d data=%0h",
                        wr_index, wr_data, e[36:32], e[31:0]);
            end else
               $display("write idx=%0d data=%0h", wr_index, wr_data);
         end
      end
   end

   // Scoreboard for the round-robin instance
   always @(negedge clk) begin
      if (!reset && mon_en && rr_wr_en) begin
         checks++;
         if (rr_exp_q.size() == 0) begin
            errors++;
            $display("FAIL rr_wr_unexpected got idx=%0d data=%0h required no write", rr_wr_index, rr_wr_data);
         end else begin
            wb_t e;
            e = rr_exp_q.pop_front();
            if ({rr_wr_index, rr_wr_data} !== e) begin
               errors++;
               $display("FAIL rr_wr_port got idx=%0d data=%0h required idx=%0d data=%0h",
                        rr_wr_index, rr_wr_data, e[36:32], e[31:0]);
            end else
               $display("rr write idx=%0d data=%0h", rr_wr_index, rr_wr_data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[5];
      int   cyc;
      int   c2_cnt;
      int   c2_sent;
      bit   got;
      wb_t  m0[$];
      wb_t  m1[$];
      int   rr_m;
      int   seq0, seq1;
      bit   r0, r1;

      vecs[0] = '{3'b111, {5'd3, 5'd2, 5'd1},  {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 4};
      vecs[1] = '{3'b101, {5'd9, 5'd0, 5'd7},  {32'h0000_0909, 32'h0,         32'h0000_0707}, 3};
      vecs[2] = '{3'b110, {5'd0, 5'd31, 5'd0}, {32'h0000_DEAD, 32'h1F1F_1F1F, 32'h0},         2};
      vecs[3] = '{3'b010, {5'd0, 5'd0, 5'd0},  {32'h0,         32'hFFFF_FFFF, 32'h0},         1};
      vecs[4] = '{3'b011, {5'd0, 5'd4, 5'd0},  {32'h0,         32'h4444_4444, 32'h5555_5555}, 3};

      reset = 1'b1;
      req_valid = '0; req_addr = '0; req_data = '0;
      rr_valid = '0;  rr_addr = '0;  rr_data = '0;
`ifdef WB_HAZARD_CHECK_EN
      chk_index1 = '0; chk_index2 = '0; rr_chk_index = '0;
`endif
      tick();
      tick();
      reset = 1'b0;
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_index", wr_index, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_req_ready", req_ready, 3'b111);
      check("rst_pending", pending, 0);
      mon_en = 1'b1;

      // Single push: write visible strictly between E1 and E2
      set_ch(0, 5'd5, 32'h1234);
      exp_q.push_back({5'd5, 32'h1234});
      tick();                                  // E0
      req_valid = '0;
      check("t1_wr_en_e0", wr_en, 0);
      check("t1_pending_e0", pending, 1);
      tick();                                  // E1
      check("t1_wr_en_e1", wr_en, 1);
      check("t1_wr_index_e1", wr_index, 5);
      check("t1_wr_data_e1", wr_data, 32'h1234);
      tick();                                  // E2
      check("t1_wr_en_e2", wr_en, 0);
      check("t1_pending_e2", pending, 0);

      // Table: one-cycle bursts, fixed priority drains in channel order without gaps
      for (int v = 0; v < 5; v++) begin
         for (int ch = 0; ch < 3; ch++) begin
            if (vecs[v].valid[ch]) begin
               set_ch(ch, vecs[v].addr[ch*5 +: 5], vecs[v].data[ch*32 +: 32]);
               if (vecs[v].addr[ch*5 +: 5] != 5'd0)
                  exp_q.push_back({vecs[v].addr[ch*5 +: 5], vecs[v].data[ch*32 +: 32]});
            end
         end
         tick();
         req_valid = '0;
         check($sformatf("vec%0d_ready", v), req_ready, 3'b111);
         check($sformatf("vec%0d_pending", v), pending, 1);
         cyc = 0;
         do begin
            tick();
            cyc++;
         end while (pending && cyc < 20);
         check($sformatf("vec%0d_drain_cycles", v), cyc, vecs[v].cycles);
         check($sformatf("vec%0d_sb_left", v), exp_q.size(), 0);
      end

      // Backpressure: ch0 hogs the port, ch2 fills after two accepts
      c2_cnt = 0;
      c2_sent = 0;
      for (int k = 0; k < 6; k++) begin
         req_valid = '0;
         set_ch(0, 5'(10 + k), 32'hA000 + k);
         exp_q.push_back({5'(10 + k), 32'hA000 + k});
         set_ch(2, 5'(20 + c2_sent), 32'hC000 + c2_sent);
         check($sformatf("t4_ready2_k%0d", k), req_ready[2], (c2_cnt < 2));
         if (c2_cnt < 2) begin
            c2_cnt++;
            c2_sent++;
         end
         tick();
      end
      req_valid = '0;
      set_ch(2, 5'd22, 32'hC002);
      exp_q.push_back({5'd20, 32'hC000});
      exp_q.push_back({5'd21, 32'hC001});
      exp_q.push_back({5'd22, 32'hC002});
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
         if (req_ready[2]) got = 1'b1;
         tick();
      end
      req_valid = '0;
      check("t4_third_accepted", got, 1);
      cyc = 0;
      while (pending && cyc < 20) begin
         tick();
         cyc++;
      end
      check("t4_sb_left", exp_q.size(), 0);
      check("t4_pending", pending, 0);

`ifdef WB_HAZARD_CHECK_EN
      // Hazard compare follows the entry from FIFO through the output register
      chk_index1 = 5'd7;
      chk_index2 = 5'd0;
      #1 check("t7_haz1_idle", chk_hazard1, 0);
      set_ch(2, 5'd7, 32'h7777);
      exp_q.push_back({5'd7, 32'h7777});
      tick();                                  // E0
      req_valid = '0;
      #1 check("t7_haz1_fifo", chk_hazard1, 1);
      check("t7_haz2_zero", chk_hazard2, 0);
      chk_index2 = 5'd7;
      #1 check("t7_haz2_fifo", chk_hazard2, 1);
      chk_index2 = 5'd6;
      #1 check("t7_haz2_other", chk_hazard2, 0);
      tick();                                  // E1
      #1 check("t7_haz1_wr", chk_hazard1, 1);
      tick();                                  // E2
      #1 check("t7_haz1_after", chk_hazard1, 0);
      chk_index1 = 5'd0;
      #1 check("t7_haz1_x0", chk_hazard1, 0);
      tick();
`endif

      // Reset with all FIFOs loaded: nothing stale may be written afterwards
      mon_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_ch(0, 5'(1 + k), 32'hD000 + k);
         set_ch(1, 5'(4 + k), 32'hD100 + k);
         set_ch(2, 5'(8 + k), 32'hD200 + k);
         tick();
      end
      req_valid = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_wr_en", wr_en, 0);
      check("t6_wr_index", wr_index, 0);
      check("t6_req_ready", req_ready, 3'b111);
      check("t6_pending", pending, 0);
      exp_q.delete();
      mon_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("t6_idle_wr_en_%0d", k), wr_en, 0);
      end

      // Round-robin: ch0 and ch1 always valid, model decides grants and accepts
      rr_m = 0; seq0 = 0; seq1 = 0;
      for (int cy = 0; cy < 30; cy++) begin
         bit active;
         int g;
         active = (cy < 10);
         if (!active && m0.size() == 0 && m1.size() == 0) break;
         rr_valid = '0;
         if (active) begin
            set_rr(0, 5'(8 + (seq0 % 8)), 32'h0A00_0000 + seq0);
            set_rr(1, 5'(16 + (seq1 % 8)), 32'h0B00_0000 + seq1);
         end
         r0 = (m0.size() < 2);
         r1 = (m1.size() < 2);
         check($sformatf("t3_ready0_%0d", cy), rr_ready[0], r0);
         check($sformatf("t3_ready1_%0d", cy), rr_ready[1], r1);
         g = -1;
         for (int k = 0; k < 3 && g < 0; k++) begin
            int c;
            c = (rr_m + k) % 3;
            if ((c == 0 && m0.size() > 0) || (c == 1 && m1.size() > 0)) g = c;
         end
         if (g == 0) rr_exp_q.push_back(m0.pop_front());
         if (g == 1) rr_exp_q.push_back(m1.pop_front());
         if (g >= 0) rr_m = (g + 1) % 3;
         if (active && r0) begin
            m0.push_back({5'(8 + (seq0 % 8)), 32'h0A00_0000 + seq0});
            seq0++;
         end
         if (active && r1) begin
            m1.push_back({5'(16 + (seq1 % 8)), 32'h0B00_0000 + seq1});
            seq1++;
         end
         tick();
      end
      rr_valid = '0;
      tick();
      check("t3_sb_left", rr_exp_q.size(), 0);
      check("t3_pending", rr_pending, 0);
      check("t3_ch1_served", (seq1 > 3), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
